// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based next-PC prediction, execute-stage branch
// resolution, misprediction flush/redirect and a saturating mispredict counter.
module pc_predict_unit #(
    parameter int unsigned           WIDTH     = 32,
    parameter int unsigned           ENTRIES   = 16,
    parameter logic [WIDTH-1:0]      RESET_PC  = '0,
    parameter int unsigned           CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    output logic [WIDTH-1:0]     fetchPC,
    output logic                 fetchPredTaken,
    output logic [WIDTH-1:0]     fetchPredTarget,
    input  logic                 executeValid,
    input  logic [WIDTH-1:0]     executePC,
    input  logic [WIDTH-1:0]     executeT,
    input  logic [WIDTH-1:0]     executeA,
    input  logic [WIDTH-1:0]     executeImmediate,
    input  logic [4:0]           executeOpcode,
    input  logic                 neq,
    input  logic                 lt,
    input  logic                 executePredTaken,
    input  logic [WIDTH-1:0]     executePredTarget,
    output logic                 flush,
    output logic [WIDTH-1:0]     correctPC,
    output logic [CNT_WIDTH-1:0] mispredictCount
);

    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = WIDTH - IDX;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    logic             btb_valid  [ENTRIES];
    logic [TAGW-1:0]  btb_tag    [ENTRIES];
    logic [WIDTH-1:0] btb_target [ENTRIES];
    logic [1:0]       btb_ctr    [ENTRIES];

    logic [IDX-1:0]   fetch_idx;
    logic             fetch_hit;
    logic [WIDTH-1:0] fetch_seq;

    logic [IDX-1:0]   exec_idx;
    logic             exec_hit;
    logic [WIDTH-1:0] exec_seq;
    logic [WIDTH-1:0] branch_target;
    logic             is_ctrl;
    logic             actual_taken;
    logic [WIDTH-1:0] actual_target;
    logic             mispredict;
    logic [WIDTH-1:0] next_pc;

    // Fetch-side lookup
    always_comb begin
        fetch_idx       = fetchPC[IDX-1:0];
        fetch_seq       = fetchPC + ONE;
        fetch_hit       = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetchPC[WIDTH-1:IDX]);
        fetchPredTaken  = fetch_hit && btb_ctr[fetch_idx][1];
        fetchPredTarget = fetch_hit ? btb_target[fetch_idx] : fetch_seq;
    end

    // Execute-side resolution
    always_comb begin
        exec_idx      = executePC[IDX-1:0];
        exec_hit      = btb_valid[exec_idx] && (btb_tag[exec_idx] == executePC[WIDTH-1:IDX]);
        exec_seq      = executePC + ONE;
        branch_target = exec_seq + executeImmediate;
        is_ctrl       = 1'b0;
        actual_taken  = 1'b0;
        actual_target = exec_seq;
        unique case (executeOpcode)
            OP_J, OP_JAL: begin
                is_ctrl       = 1'b1;
                actual_taken  = 1'b1;
                actual_target = executeT;
            end
            OP_JR: begin
                is_ctrl       = 1'b1;
                actual_taken  = 1'b1;
                actual_target = executeA;
            end
            OP_BNE: begin
                is_ctrl       = 1'b1;
                actual_taken  = neq;
                actual_target = branch_target;
            end
            OP_BLT: begin
                is_ctrl       = 1'b1;
                actual_taken  = lt;
                actual_target = branch_target;
            end
            OP_BEX: begin
                is_ctrl       = 1'b1;
                actual_taken  = neq;
                actual_target = executeT;
            end
            default: ;
        endcase
        mispredict = executeValid &&
                     ((actual_taken != executePredTaken) ||
                      (actual_taken && (actual_target != executePredTarget)));
        flush      = mispredict;
        correctPC  = actual_taken ? actual_target : exec_seq;
    end

    always_comb begin
        if (flush)               next_pc = correctPC;
        else if (stall)          next_pc = fetchPC;
        else if (fetchPredTaken) next_pc = fetchPredTarget;
        else                     next_pc = fetch_seq;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fetchPC <= RESET_PC;
        else        fetchPC <= next_pc;
    end

    // Non-blocking writes keep same-cycle lookups on the pre-write contents
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (executeValid) begin
            if (is_ctrl) begin
                if (actual_taken) begin
                    btb_target[exec_idx] <= actual_target;
                    if (exec_hit) begin
                        if (btb_ctr[exec_idx] != 2'b11)
                            btb_ctr[exec_idx] <= btb_ctr[exec_idx] + 2'd1;
                    end else begin
                        btb_valid[exec_idx] <= 1'b1;
                        btb_tag[exec_idx]   <= executePC[WIDTH-1:IDX];
                        btb_ctr[exec_idx]   <= 2'b10;
                    end
                end else if (exec_hit && (btb_ctr[exec_idx] != 2'b00)) begin
                    btb_ctr[exec_idx] <= btb_ctr[exec_idx] - 2'd1;
                end
            end else if (exec_hit) begin
                btb_valid[exec_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            mispredictCount <= '0;
        else if (flush && (mispredictCount != '1))
            mispredictCount <= mispredictCount + CNT_WIDTH'(1);
    end

endmodule
